// File: rtl/rnd_feed_hpc3_pkg.sv
// Shared constants, state encoding and width helper for the HPC3 randomness feeder.
package rnd_feed_hpc3_pkg;

   localparam int LFSR_W = 32;

   // Fibonacci taps for x^32 + x^22 + x^2 + x + 1
   localparam int TAP0 = 31;
   localparam int TAP1 = 21;
   localparam int TAP2 = 1;
   localparam int TAP3 = 0;

   localparam logic [LFSR_W-1:0] LFSR_SUBST = 32'h0000_0001;

   typedef enum logic [1:0] {
      IDLE,
      SEED,
      WARMUP,
      RUN
   } state_t;

   function automatic int calc_rw(input int d, input int n);
      return n * d * (d + 1);
   endfunction

endpackage

// File: rtl/rnd_feed_hpc3_lfsr32_step.sv
// One 32-bit Fibonacci LFSR: load (zero replaced by LFSR_SUBST) beats step beats hold.
// o_bit is the current MSB, i.e. the bit consumed by the step about to happen.
module lfsr32_step
   import rnd_feed_hpc3_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [LFSR_W-1:0] i_seed,
   input  logic              i_step,
   output logic              o_bit
);

   logic [LFSR_W-1:0] r_state;
   logic              w_fb;

   assign w_fb  = r_state[TAP0] ^ r_state[TAP1] ^ r_state[TAP2] ^ r_state[TAP3];
   assign o_bit = r_state[LFSR_W-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= '0;
      end else if (i_load) begin
         r_state <= (i_seed == '0) ? LFSR_SUBST : i_seed;
      end else if (i_step) begin
         r_state <= {r_state[LFSR_W-2:0], w_fb};
      end
   end

endmodule

// File: rtl/rnd_feed_hpc3.sv
// Per-bit LFSR randomness for HPC3 gadgets; rnd/rnd_valid registered, visible the cycle after en=1, en=0 stalls.
// Serial seeding via seed_valid/seed_ready (not ready during warmup); RND_FEED_FORCE_ZERO_EN ties rnd to zero.
module rnd_feed_hpc3
   import rnd_feed_hpc3_pkg::*;
#(
   parameter  int security_order = 1,
   parameter  int n_gadgets      = 1,
   parameter  int warmup         = 32,
   localparam int RW             = calc_rw(security_order, n_gadgets)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [LFSR_W-1:0] seed,
   input  logic              seed_valid,
   output logic              seed_ready,
   input  logic              en,
   output logic [RW-1:0]     rnd,
   output logic              rnd_valid
);

   localparam int     IDX_W         = $clog2(RW + 1);
   localparam int     WC_W          = (warmup > 1) ? $clog2(warmup) : 1;
   localparam state_t ST_AFTER_SEED = (warmup == 0) ? RUN : WARMUP;

   state_t           r_state, w_state_nxt;
   logic [IDX_W-1:0] r_idx, w_idx_nxt, w_load_idx;
   logic [WC_W-1:0]  r_wcnt, w_wcnt_nxt;
   logic [RW-1:0]    r_rnd, w_bits, w_load;
   logic             r_rnd_valid;
   logic             w_xfer, w_last, w_step;

   assign seed_ready = !rst && (r_state != WARMUP);
   assign w_xfer     = seed_valid && seed_ready;

   // Outside SEED every accepted word restarts the bank at LFSR 0
   assign w_load_idx = (r_state == SEED) ? r_idx : '0;
   assign w_last     = (w_load_idx == IDX_W'(RW - 1));
   assign w_step     = (r_state == WARMUP) || ((r_state == RUN) && en && !w_xfer);

   always_comb begin
      w_load = '0;
      for (int i = 0; i < RW; i++) begin
         w_load[i] = w_xfer && (w_load_idx == IDX_W'(i));
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_wcnt_nxt  = r_wcnt;
      case (r_state)
         IDLE, SEED, RUN: begin
            if (w_xfer) begin
               w_idx_nxt   = w_load_idx + 1'b1;
               w_wcnt_nxt  = '0;
               w_state_nxt = w_last ? ST_AFTER_SEED : SEED;
            end
         end
         WARMUP: begin
            w_wcnt_nxt = r_wcnt + 1'b1;
            if (r_wcnt == WC_W'(warmup - 1)) begin
               w_state_nxt = RUN;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_wcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_wcnt  <= w_wcnt_nxt;
      end
   end

   for (genvar g = 0; g < RW; g++) begin : g_lfsr
      lfsr32_step u_lfsr (
         .clk    (clk),
         .rst    (rst),
         .i_load (w_load[g]),
         .i_seed (seed),
         .i_step (w_step),
         .o_bit  (w_bits[g])
      );
   end

   // rnd_valid only ever leaves 0 in RUN, and RUN is only left by a reseed or reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rnd       <= '0;
         r_rnd_valid <= 1'b0;
      end else if ((r_state == RUN) && w_xfer) begin
         r_rnd       <= '0;
         r_rnd_valid <= 1'b0;
      end else if ((r_state == RUN) && en) begin
         r_rnd       <= w_bits;
         r_rnd_valid <= 1'b1;
      end
   end

`ifdef RND_FEED_FORCE_ZERO_EN
   assign rnd = '0;
`else
   assign rnd = r_rnd;
`endif
   assign rnd_valid = r_rnd_valid;

endmodule

// File: tb/tb_rnd_feed_hpc3.sv
// Bench for rnd_feed_hpc3: two instances (warmup 0 and 32, RW=2) share stimulus and are checked against
// a per-LFSR sequence model of the bit stream.
module tb_rnd_feed_hpc3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] seed = '0;
   logic        seed_valid = 1'b0;
   logic        en = 1'b0;

   logic [1:0]  rnd0, rnd1;
   logic        rnd_valid0, rnd_valid1, seed_ready0, seed_ready1;

   int errors = 0;
   int checks = 0;

   // model state: one 32-bit sequence per output bit, per instance
   logic [31:0] m0 [2];
   logic [31:0] m1 [2];
   logic [1:0]  e0, e1;
   logic        ev0, ev1;
   int          w1left;

   always #5 clk = ~clk;

   rnd_feed_hpc3 #(.security_order(1), .n_gadgets(1), .warmup(0)) u_dut0 (
      .clk        (clk),
      .rst        (rst),
      .seed       (seed),
      .seed_valid (seed_valid),
      .seed_ready (seed_ready0),
      .en         (en),
      .rnd        (rnd0),
      .rnd_valid  (rnd_valid0)
   );

   rnd_feed_hpc3 #(.security_order(1), .n_gadgets(1), .warmup(32)) u_dut32 (
      .clk        (clk),
      .rst        (rst),
      .seed       (seed),
      .seed_valid (seed_valid),
      .seed_ready (seed_ready1),
      .en         (en),
      .rnd        (rnd1),
      .rnd_valid  (rnd_valid1)
   );

   function automatic logic [31:0] lstep(input logic [31:0] s);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
   endfunction

   function automatic logic [31:0] fixz(input logic [31:0] s);
      return (s == 32'h0) ? 32'h1 : s;
   endfunction

   function automatic logic [1:0] ezr(input logic [1:0] x);
`ifdef RND_FEED_FORCE_ZERO_EN
      return 2'b00 & x;
`else
      return x;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      seed_valid = 1'b0;
      en = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic set_models(input logic [31:0] s0, input logic [31:0] s1);
      m0[0] = fixz(s0);
      m0[1] = fixz(s1);
      m1[0] = fixz(s0);
      m1[1] = fixz(s1);
      for (int i = 0; i < 32; i++) begin
         m1[0] = lstep(m1[0]);
         m1[1] = lstep(m1[1]);
      end
      e0 = 2'b00; ev0 = 1'b0;
      e1 = 2'b00; ev1 = 1'b0;
      w1left = 32;
   endtask

   task automatic seed_both(input logic [31:0] s0, input logic [31:0] s1);
      en = 1'b0;
      seed_valid = 1'b1;
      seed = s0;
      tick();
      seed = s1;
      tick();
      seed_valid = 1'b0;
      set_models(s0, s1);
   endtask

   task automatic run_random_en(input int n, input string tag);
      for (int k = 0; k < n; k++) begin
         en = 1'($urandom_range(0, 1));
         tick();
         if (en) begin
            e0 = {m0[1][31], m0[0][31]};
            m0[0] = lstep(m0[0]);
            m0[1] = lstep(m0[1]);
            ev0 = 1'b1;
         end
         if (w1left > 0) begin
            w1left--;
         end else if (en) begin
            e1 = {m1[1][31], m1[0][31]};
            m1[0] = lstep(m1[0]);
            m1[1] = lstep(m1[1]);
            ev1 = 1'b1;
         end
         checks += 4;
         if (rnd0 !== ezr(e0)) begin
            errors++;
            $display("FAIL %s rnd0 cyc %0d: got %b expected %b", tag, k, rnd0, ezr(e0));
         end
         if (rnd_valid0 !== ev0) begin
            errors++;
            $display("FAIL %s rnd_valid0 cyc %0d: got %b expected %b", tag, k, rnd_valid0, ev0);
         end
         if (rnd1 !== ezr(e1)) begin
            errors++;
            $display("FAIL %s rnd1 cyc %0d: got %b expected %b", tag, k, rnd1, ezr(e1));
         end
         if (rnd_valid1 !== ev1) begin
            errors++;
            $display("FAIL %s rnd_valid1 cyc %0d: got %b expected %b", tag, k, rnd_valid1, ev1);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      seed_valid = 1'b1;
      seed = 32'hDEAD_BEEF;
      tick();
      checks += 2;
      if (seed_ready0 !== 1'b0) begin
         errors++;
         $display("FAIL reset seed_ready0: got %b expected 0", seed_ready0);
      end
      if (seed_ready1 !== 1'b0) begin
         errors++;
         $display("FAIL reset seed_ready1: got %b expected 0", seed_ready1);
      end
      tick();
      rst = 1'b0;
      seed_valid = 1'b0;
      tick();
      checks += 4;
      if ({rnd0, rnd1} !== 4'b0000) begin
         errors++;
         $display("FAIL idle rnd: got %b/%b expected 00/00", rnd0, rnd1);
      end
      if ({rnd_valid0, rnd_valid1} !== 2'b00) begin
         errors++;
         $display("FAIL idle rnd_valid: got %b%b expected 00", rnd_valid0, rnd_valid1);
      end
      if (seed_ready0 !== 1'b1) begin
         errors++;
         $display("FAIL idle seed_ready0: got %b expected 1", seed_ready0);
      end
      if (seed_ready1 !== 1'b1) begin
         errors++;
         $display("FAIL idle seed_ready1: got %b expected 1", seed_ready1);
      end
   endtask

   task automatic test_directed();
      do_reset();
      seed_both(32'h8000_0000, 32'h0);
      en = 1'b1;
      tick();
      checks += 3;
      if (rnd0 !== ezr(2'b01)) begin
         errors++;
         $display("FAIL directed first rnd0: got %b expected %b", rnd0, ezr(2'b01));
      end
      if (rnd_valid0 !== 1'b1) begin
         errors++;
         $display("FAIL directed rnd_valid0: got %b expected 1", rnd_valid0);
      end
      if (rnd_valid1 !== 1'b0) begin
         errors++;
         $display("FAIL directed warmup rnd_valid1: got %b expected 0", rnd_valid1);
      end
      tick();
      checks++;
      if (rnd0 !== 2'b00) begin
         errors++;
         $display("FAIL directed second rnd0: got %b expected 00", rnd0);
      end
   endtask

   task automatic test_stall();
      logic [1:0] exp_seq [4];
      logic       en_seq [4];
      exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b01; exp_seq[3] = 2'b00;
      en_seq[0] = 1'b1; en_seq[1] = 1'b0; en_seq[2] = 1'b0; en_seq[3] = 1'b1;
      do_reset();
      seed_both(32'h8000_0000, 32'h0);
      for (int k = 0; k < 4; k++) begin
         en = en_seq[k];
         tick();
         checks += 2;
         if (rnd0 !== ezr(exp_seq[k])) begin
            errors++;
            $display("FAIL stall rnd0 step %0d: got %b expected %b", k, rnd0, ezr(exp_seq[k]));
         end
         if (rnd_valid0 !== 1'b1) begin
            errors++;
            $display("FAIL stall rnd_valid0 step %0d: got %b expected 1", k, rnd_valid0);
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      seed_both($urandom, $urandom);
      run_random_en(150, "random");
   endtask

   task automatic test_warmup_latency();
      int rise0 = -1;
      int rise1 = -1;
      int rdy_bad = 0;
      do_reset();
      en = 1'b1;
      seed_valid = 1'b1;
      seed = $urandom;
      for (int k = 1; k <= 100; k++) begin
         tick();
         if (k == 1) seed = $urandom;
         if (k == 2) seed_valid = 1'b0;
         if (rise0 < 0 && rnd_valid0 === 1'b1) rise0 = k;
         if (rise1 < 0 && rnd_valid1 === 1'b1) rise1 = k;
         if (k >= 2 && k <= 33 && seed_ready1 !== 1'b0) rdy_bad++;
         if (rise1 >= 0) break;
      end
      checks += 3;
      if (rise0 != 3) begin
         errors++;
         $display("FAIL latency warmup0: rnd_valid rose at %0d expected 3", rise0);
      end
      if (rise1 != 35) begin
         errors++;
         $display("FAIL latency warmup32: rnd_valid rose at %0d expected 35", rise1);
      end
      if (rdy_bad != 0) begin
         errors++;
         $display("FAIL warmup seed_ready: high in %0d warmup cycles expected 0", rdy_bad);
      end
   endtask

   task automatic test_reseed_in_run();
      logic [31:0] s0, s1;
      s0 = $urandom;
      s1 = $urandom;
      en = 1'b1;
      tick();
      tick();
      en = 1'b0;
      seed_valid = 1'b1;
      seed = s0;
      tick();
      checks += 3;
      if ({rnd_valid0, rnd_valid1} !== 2'b00) begin
         errors++;
         $display("FAIL reseed rnd_valid: got %b%b expected 00", rnd_valid0, rnd_valid1);
      end
      if ({rnd0, rnd1} !== 4'b0000) begin
         errors++;
         $display("FAIL reseed rnd clear: got %b/%b expected 00/00", rnd0, rnd1);
      end
      if ({seed_ready0, seed_ready1} !== 2'b11) begin
         errors++;
         $display("FAIL reseed seed_ready mid-seed: got %b%b expected 11", seed_ready0, seed_ready1);
      end
      seed = s1;
      tick();
      seed_valid = 1'b0;
      set_models(s0, s1);
      run_random_en(100, "reseed");
   endtask

   task automatic test_rst_mid_seed();
      do_reset();
      seed_valid = 1'b1;
      seed = $urandom;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      seed_valid = 1'b0;
      tick();
      checks += 2;
      if ({seed_ready0, seed_ready1} !== 2'b11) begin
         errors++;
         $display("FAIL rst-mid-seed seed_ready: got %b%b expected 11", seed_ready0, seed_ready1);
      end
      if ({rnd_valid0, rnd_valid1} !== 2'b00) begin
         errors++;
         $display("FAIL rst-mid-seed rnd_valid: got %b%b expected 00", rnd_valid0, rnd_valid1);
      end
      seed_both(32'h0, $urandom);
      run_random_en(100, "rst_mid_seed");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stall();
      test_random();
      test_warmup_latency();
      test_reseed_in_run();
      test_rst_mid_seed();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
